// File: rtl/if_fetch_stage.sv
// MIPS instruction fetch stage: PC owner, imem req/ack client, 1-entry park buffer, redirect/drain.
// Optional IF_ALIGN_CHECK_EN adds a sticky addr_err flag for misaligned redirect targets.
`timescale 1ns/1ps
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_PARK,
        S_DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] park;
    logic [31:0] park_pc;
    logic        free;
    logic [31:0] redirect_aligned;

    assign free             = !instr_valid || !stall;
    assign redirect_aligned = redirect_pc & ~32'h0000_0003;
    assign imem_addr        = pc;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc_out      <= '0;
            pc_plus4    <= '0;
            park        <= '0;
            park_pc     <= '0;
`ifdef IF_ALIGN_CHECK_EN
            addr_err    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // An unacked request must still be drained; its data belongs to the old path.
            pc          <= redirect_aligned;
            instr_valid <= 1'b0;
            park        <= '0;
            park_pc     <= '0;
            imem_req    <= 1'b1;
            state       <= (imem_req && !imem_ack) ? S_DRAIN : S_REQ;
`ifdef IF_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                addr_err <= 1'b1;
            end
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (free) begin
                            instr       <= imem_rdata;
                            pc_out      <= pc;
                            pc_plus4    <= pc + 32'd4;
                            instr_valid <= 1'b1;
                        end else begin
                            park     <= imem_rdata;
                            park_pc  <= pc;
                            imem_req <= 1'b0;
                            state    <= S_PARK;
                        end
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                end
                S_PARK: begin
                    if (!stall) begin
                        instr       <= park;
                        pc_out      <= park_pc;
                        pc_plus4    <= park_pc + 32'd4;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed fetch, stall/park, redirect, wrap and reset scenarios.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
`ifdef IF_ALIGN_CHECK_EN
    logic        addr_err;
`endif

    if_fetch_stage #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .funct          (funct),
        .imm16          (imm16)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .addr_err       (addr_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          accepted = 0;
    int          pushed = 0;
    int          budget = 0;
    int          cnt = 0;
    logic [31:0] lat_addr = 32'h0;
    logic [31:0] sext_q = 32'h0;
    logic [31:0] sext_exp = 32'h0;
    bit          sext_pend = 1'b0;

    // Instruction memory contents: distinct word per address, 0x0 holds addi $t0,$zero,-1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_FFFF;
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] a);
        sbq.push_back(exp_t'{pc: a, word: mem_word(a)});
        pushed++;
    endtask

    // Memory latches the address at request start and acks one cycle later while budget lasts.
    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            cnt        = 0;
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end else begin
            if (cnt == 0) lat_addr = imem_addr;
            if (cnt >= 1 && budget > 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(lat_addr);
                budget     = budget - 1;
                cnt        = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                cnt        = cnt + 1;
            end
        end
    end

    // Downstream sign-extension stage model.
    always @(posedge clk) sext_q <= {{16{imm16[15]}}, imm16};

    always @(negedge clk) begin
        if (sext_pend) begin
            chk("sext", sext_q, sext_exp);
            sext_pend = 1'b0;
        end
        if (rst_n && instr_valid && !stall) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr: got pc %h instr %h expected none", pc_out, instr);
            end else begin
                mon_e = sbq.pop_front();
                chk("instr", instr, mon_e.word);
                chk("pc_out", pc_out, mon_e.pc);
                chk("pc_plus4", pc_plus4, mon_e.pc + 32'd4);
                chk("fields", {opcode, rs, rt, rd, shamt, funct}, mon_e.word);
                chk("imm16", {16'h0, imm16}, {16'h0, mon_e.word[15:0]});
                sext_exp  = {{16{mon_e.word[15]}}, mon_e.word[15:0]};
                sext_pend = 1'b1;
            end
            accepted++;
        end
    end

    task automatic wait_sb(input string name);
        int n = 0;
        while (accepted < pushed && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (accepted < pushed) begin
            failures++;
            $display("FAIL %s: timeout, accepted %0d expected %0d", name, accepted, pushed);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!instr_valid && n < 50);
        chk(name, {31'h0, instr_valid}, 32'd1);
    endtask

    task automatic wait_park(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (imem_req && n < 50);
        chk(name, {31'h0, imem_req}, 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_pc    = a;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        budget = 3;
        #12;
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h0);
        chk("rst_addr", imem_addr, RPC);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC
        expect_word(32'h0040_0000);
        expect_word(32'h0040_0004);
        expect_word(32'h0040_0008);
        wait_sb("seq_fetch");
        chk("seq_next_addr", imem_addr, 32'h0040_000C);
        chk("seq_req_held", {31'h0, imem_req}, 32'd1);
        chk("seq_consumed", {31'h0, instr_valid}, 32'd0);

        // Stall with an ack arriving: park, then release
        expect_word(32'h0040_000C);
        expect_word(32'h0040_0010);
        budget = 2;
        wait_valid("stall_first_valid");
        stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_instr_held", instr, mem_word(32'h0040_000C));
        chk("stall_pc_held", pc_out, 32'h0040_000C);
        chk("stall_req_low", {31'h0, imem_req}, 32'd0);
        chk("stall_valid", {31'h0, instr_valid}, 32'd1);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("unpark_instr", instr, mem_word(32'h0040_0010));
        chk("unpark_pc", pc_out, 32'h0040_0010);
        wait_sb("park_release");
        chk("after_park_addr", imem_addr, 32'h0040_0014);

        // Redirect with a request outstanding: drain stale ack
        do_redirect(32'h0000_0100);
        chk("drain_valid", {31'h0, instr_valid}, 32'd0);
        chk("drain_req", {31'h0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h0000_0100);
        expect_word(32'h0000_0100);
        budget = 2;
        wait_sb("drain_redirect");

        // Redirect coincident with ack
        budget = 1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (!imem_ack && n < 20);
            chk("coinc_ack_seen", {31'h0, imem_ack}, 32'd1);
        end
        do_redirect(32'h0000_0200);
        chk("coinc_valid", {31'h0, instr_valid}, 32'd0);
        chk("coinc_req", {31'h0, imem_req}, 32'd1);
        chk("coinc_addr", imem_addr, 32'h0000_0200);
        chk("coinc_instr_kept", instr, mem_word(32'h0000_0100));
        expect_word(32'h0000_0200);
        budget = 1;
        wait_sb("coinc_redirect");

        // Redirect while parked: both held and parked words dropped
        budget = 2;
        wait_valid("park2_valid");
        stall = 1'b1;
        wait_park("park2_req_low");
        do_redirect(32'h0000_0300);
        chk("parkredir_valid", {31'h0, instr_valid}, 32'd0);
        chk("parkredir_req", {31'h0, imem_req}, 32'd1);
        chk("parkredir_addr", imem_addr, 32'h0000_0300);
        stall = 1'b0;
        expect_word(32'h0000_0300);
        budget = 1;
        wait_sb("park_redirect");

        // PC wrap and field split of 0x2008FFFF at address 0
        do_redirect(32'hFFFF_FFFC);
        expect_word(32'hFFFF_FFFC);
        expect_word(32'h0000_0000);
        budget = 3;
        wait_sb("wrap_fetch");
        chk("f_opcode", {26'h0, opcode}, 32'h08);
        chk("f_rs", {27'h0, rs}, 32'h0);
        chk("f_rt", {27'h0, rt}, 32'h8);
        chk("f_imm16", {16'h0, imm16}, 32'h0000_FFFF);
        chk("f_pc_plus4", pc_plus4, 32'h0000_0004);
        chk("f_sext", sext_q, 32'hFFFF_FFFF);

        // Asynchronous reset while parked
        budget = 2;
        wait_valid("park3_valid");
        stall = 1'b1;
        wait_park("park3_req_low");
        budget = 0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'd0);
        chk("arst_valid", {31'h0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_pc_out", pc_out, 32'h0);
        chk("arst_pc_plus4", pc_plus4, 32'h0);
        chk("arst_addr", imem_addr, RPC);
`ifdef IF_ALIGN_CHECK_EN
        chk("arst_addr_err", {31'h0, addr_err}, 32'd0);
`endif
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Misaligned redirect target
        do_redirect(32'h0000_0103);
        chk("mis_addr", imem_addr, 32'h0000_0100);
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_addr_err", {31'h0, addr_err}, 32'd1);
`endif
        expect_word(32'h0000_0100);
        budget = 2;
        wait_sb("misaligned_fetch");
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_addr_err_sticky", {31'h0, addr_err}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage of the soft-core MIPS pipeline, directly upstream of the immediate sign-extension stage.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Holds the fetched word in an output register and splits it into MIPS fields; imm16 drives the sign-extension stage.
- Supports downstream stall through a 1-entry park buffer, and branch/jump redirect with discard of an in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, level
imem_addr  out  32  fetch byte address, word aligned
imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
stall  in  1  downstream cannot accept a new instruction
redirect_valid  in  1  one-cycle redirect strobe
redirect_pc  in  32  new fetch address
instr_valid  out  1  output register holds a valid instruction
instr  out  32  instruction word
pc_out  out  32  address of instr
pc_plus4  out  32  pc_out + 4
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
imm16  out  16  instr[15:0], to sign-extension stage

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0.
  - instr, pc_out, pc_plus4 and park buffer are all 0.
- Field outputs are combinational slices of the instr register.
- Sign extension registers imm16 one cycle later. While stall=1, instr is held stable, so the extended immediate stays aligned.
- imem_addr = pc whenever imem_req=1.
- Once raised, imem_req stays high until the ack cycle. It drops in the ack cycle's next edge unless re-issued.
- Output register "free" = !instr_valid || !stall.

FSM:
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req=1.
  - On ack with slot free: instr<=rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, stay REQ. Back-to-back fetch allows 1 instr/cycle if memory acks every cycle.
  - On ack with slot not free: park<=rdata, park_pc<=pc, pc<=pc+4 -> PARK.
- PARK: imem_req=0. When stall=0: instr<=park, pc_out<=park_pc, instr_valid<=1 -> REQ.
- DRAIN: imem_req=1 held for the outstanding request. On ack, data is discarded -> REQ, now fetching the redirected pc.
- Consume with no new word: stall=0 and no ack (or data discarded) -> instr_valid<=0 next edge.

Redirect (highest priority, any state):
- pc<=redirect_pc, instr_valid<=0, park discarded.
- If a request is outstanding without ack this cycle -> DRAIN. Otherwise -> REQ.
- Redirect coincident with ack: the acked word is discarded and the next state is REQ.
- redirect_pc[1:0] are forced to 00.
- pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- pc_plus4 is computed modulo 2^32.

Optional Feature:
Macro IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output port addr_err (1 bit, reset 0).
  - addr_err is set sticky when a redirect arrives with redirect_pc[1:0]!=0; the address is still force-aligned.
  - addr_err clears only on reset.
- Undefined: no port is added and misaligned bits are cleared silently.

Test Plan:
1. Reset, RESET_PC=32'h0040_0000, memory acks one cycle after each req, no stall.
   -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008.
   -> instr_valid rises; pc_plus4=pc_out+4.
2. Word 32'h2008_FFFF at 0x0.
   -> opcode=6'h08, rs=0, rt=8, imm16=16'hFFFF.
   -> downstream sign extension yields 32'hFFFF_FFFF one cycle later.
3. stall=1 for 5 cycles while the next ack arrives.
   -> instr and pc_out unchanged, word parked, imem_req=0.
   -> after stall=0, the parked word appears next cycle with the correct pc; no word lost or duplicated.
4. Redirect to 0x0000_0100 while a request is pending.
   -> DRAIN; the stale ack data never reaches instr; next imem_addr=0x100; instr_valid=0 in between.
5. Redirect coincident with ack, and redirect while in PARK.
   -> both words discarded; fetch resumes at redirect_pc.
6. rst_n asserted mid-WAIT/PARK.
   -> all outputs return to reset values immediately.
   -> redirect_pc=0x103 with IF_ALIGN_CHECK_EN defined: fetch at 0x100, addr_err=1; not defined: fetch at 0x100, no flag.
